// File: rtl/clk_debug_divider.sv
// clk_debug_divider: multi-channel debug clock divider with PLL lock monitor
// and heartbeat LED, all clocked by the PLL output clock.
// Optional build macro: CLKDBG_SYNC_RESTART_EN. When it is defined, a divider
// load restarts every channel phase-aligned on the following cycle. When it is
// undefined, each channel picks up its new value at its own terminal count.
module clk_debug_divider #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 1,
  parameter int HB_W        = 24,
  parameter int LOSS_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    div_load,
  input  logic [NUM_CH*CNT_W-1:0] div_value,
  input  logic                    pll_locked,
  input  logic                    lock_lost_clear,
  output logic [NUM_CH-1:0]       debug_clk_out,
  output logic                    heartbeat_led,
  output logic                    lock_lost,
  output logic [LOSS_W-1:0]       loss_count,
  output logic                    locked_sync
);

  localparam logic [CNT_W-1:0]  DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_active [NUM_CH];
  logic [CNT_W-1:0]  r_shadow [NUM_CH];
  logic              r_out    [NUM_CH];

  logic              r_sync1;
  logic              r_sync2;
  logic              r_syncPrev;
  logic              r_lockLost;
  logic [LOSS_W-1:0] r_lossCnt;
  logic [HB_W-1:0]   r_hbCnt;
  logic              w_lossEdge;

  // Shadow registers capture every load, even while the counters are frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= DEF_DIV;
    end else if (div_load) begin
      for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= div_value[i*CNT_W +: CNT_W];
    end
  end

`ifdef CLKDBG_SYNC_RESTART_EN
  logic r_restart;

  // Remember that a load happened so all channels restart together next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_restart <= 1'b0;
    else          r_restart <= div_load;
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_tc;
    assign w_tc = (r_active[g] != '0) && (r_cnt[g] == r_active[g] - ONE);

`ifdef CLKDBG_SYNC_RESTART_EN
    // Phase-aligned restart on load; otherwise count and toggle at terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt[g]    <= '0;
        r_active[g] <= DEF_DIV;
        r_out[g]    <= 1'b0;
      end else if (r_restart) begin
        r_cnt[g]    <= '0;
        r_active[g] <= r_shadow[g];
        r_out[g]    <= 1'b0;
      end else if (enable) begin
        if (r_active[g] == '0) begin
          r_cnt[g] <= '0;
          r_out[g] <= 1'b0;
        end else if (w_tc) begin
          r_cnt[g] <= '0;
          r_out[g] <= ~r_out[g];
        end else begin
          r_cnt[g] <= r_cnt[g] + ONE;
        end
      end
    end
`else
    logic [CNT_W-1:0] w_nextDiv;
    assign w_nextDiv = div_load ? div_value[g*CNT_W +: CNT_W] : r_shadow[g];

    // Count and toggle; a new divide value is only taken at terminal count
    // (or straight away when parked) so no half-period is ever cut short.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt[g]    <= '0;
        r_active[g] <= DEF_DIV;
        r_out[g]    <= 1'b0;
      end else if (enable) begin
        if (r_active[g] == '0) begin
          r_cnt[g]    <= '0;
          r_active[g] <= r_shadow[g];
          r_out[g]    <= 1'b0;
        end else if (w_tc) begin
          r_cnt[g]    <= '0;
          r_active[g] <= w_nextDiv;
          r_out[g]    <= (w_nextDiv == '0) ? 1'b0 : ~r_out[g];
        end else begin
          r_cnt[g]    <= r_cnt[g] + ONE;
        end
      end
    end
`endif
  end

  // Pack the per-channel output flops onto the output bus.
  always_comb begin
    debug_clk_out = '0;
    for (int i = 0; i < NUM_CH; i++) debug_clk_out[i] = r_out[i];
  end

  // Two-flop synchroniser for the asynchronous lock signal, plus its delayed copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_syncPrev <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

  assign w_lossEdge = r_syncPrev & ~r_sync2;

  // Sticky loss flag and saturating loss counter; a new loss beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lockLost <= 1'b0;
      r_lossCnt  <= '0;
    end else begin
      if (w_lossEdge) begin
        r_lockLost <= 1'b1;
        if (r_lossCnt != LOSS_MAX) r_lossCnt <= r_lossCnt + 1'b1;
      end else if (lock_lost_clear) begin
        r_lockLost <= 1'b0;
      end
    end
  end

  // Free-running heartbeat counter, independent of the divider enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_hbCnt <= '0;
    else          r_hbCnt <= r_hbCnt + 1'b1;
  end

  assign locked_sync   = r_sync2;
  assign lock_lost     = r_lockLost;
  assign loss_count    = r_lossCnt;
  assign heartbeat_led = r_hbCnt[HB_W-1] & r_sync2;

endmodule

// File: tb/tb_clk_debug_divider.sv
// Testbench for clk_debug_divider: directed phases followed by random stimulus,
// expected outputs pushed into a queue and compared by a separate monitor.
module tb_clk_debug_divider;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 1;
  localparam int HB_W        = 4;
  localparam int LOSS_W      = 2;
  localparam int LOSS_MAX    = (1 << LOSS_W) - 1;

  logic                    clk;
  logic                    reset_n;
  logic                    enable;
  logic                    div_load;
  logic [NUM_CH*CNT_W-1:0] div_value;
  logic                    pll_locked;
  logic                    lock_lost_clear;
  logic [NUM_CH-1:0]       debug_clk_out;
  logic                    heartbeat_led;
  logic                    lock_lost;
  logic [LOSS_W-1:0]       loss_count;
  logic                    locked_sync;

  clk_debug_divider #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV),
    .HB_W(HB_W), .LOSS_W(LOSS_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .div_load(div_load),
    .div_value(div_value), .pll_locked(pll_locked),
    .lock_lost_clear(lock_lost_clear), .debug_clk_out(debug_clk_out),
    .heartbeat_led(heartbeat_led), .lock_lost(lock_lost),
    .loss_count(loss_count), .locked_sync(locked_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] dbg;
    logic              led;
    logic              lost;
    int                loss;
    logic              sync;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: each channel is described by how many enabled cycles
  // remain until its next toggle; lock status is derived from a history of
  // the sampled pll_locked input.
  int  mDiv    [NUM_CH];
  int  mRemain [NUM_CH];
  int  mShadow [NUM_CH];
  bit  mOut    [NUM_CH];
  bit  pllHist[$];
  int  mCycles;
  bit  mLockLost;
  int  mLoss;

  function automatic bit histAt(int idx);
    if (idx < 0 || idx >= pllHist.size()) return 1'b0;
    return pllHist[idx];
  endfunction

  // locked_sync is the input seen two edges ago; a loss is pending when it
  // was 1 one edge earlier than that and is 0 now.
  function automatic bit syncNow();
    return histAt(pllHist.size() - 2);
  endfunction

  function automatic bit fallPending();
    return histAt(pllHist.size() - 3) && !histAt(pllHist.size() - 2);
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      mDiv[c] = DEFAULT_DIV; mRemain[c] = DEFAULT_DIV;
      mShadow[c] = DEFAULT_DIV; mOut[c] = 1'b0;
    end
    pllHist.delete();
    mCycles = 0; mLockLost = 1'b0; mLoss = 0;
  endfunction

  function automatic void modelStep(bit en, bit ld, logic [NUM_CH*CNT_W-1:0] val,
                                    bit pll, bit clr);
    bit fall;
    for (int c = 0; c < NUM_CH; c++) begin
      int newVal;
      newVal = int'(val[c*CNT_W +: CNT_W]);
      if (en) begin
        if (mDiv[c] == 0) begin
          mDiv[c] = mShadow[c]; mRemain[c] = mDiv[c]; mOut[c] = 1'b0;
        end else begin
          mRemain[c]--;
          if (mRemain[c] == 0) begin
            int nd;
            nd = ld ? newVal : mShadow[c];
            mOut[c] = !mOut[c];
            mDiv[c] = nd; mRemain[c] = nd;
            if (nd == 0) mOut[c] = 1'b0;
          end
        end
      end
      if (ld) mShadow[c] = newVal;
    end
    fall = fallPending();
    if (fall) begin
      mLockLost = 1'b1;
      if (mLoss < LOSS_MAX) mLoss++;
    end else if (clr) begin
      mLockLost = 1'b0;
    end
    pllHist.push_back(pll);
    if (pllHist.size() > 6) void'(pllHist.pop_front());
    mCycles++;
  endfunction

  function automatic exp_t modelOutputs();
    exp_t e;
    int hb;
    for (int c = 0; c < NUM_CH; c++) e.dbg[c] = mOut[c];
    e.sync = syncNow();
    hb = mCycles % (1 << HB_W);
    e.led  = ((hb >> (HB_W - 1)) & 1) && e.sync;
    e.lost = mLockLost;
    e.loss = mLoss;
    return e;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue what the DUT
  // must show after the following rising edge.
  task automatic applyStimulus(input bit rstn, input bit en, input bit ld,
                               input logic [NUM_CH*CNT_W-1:0] val,
                               input bit pll, input bit clr);
    @(negedge clk);
    reset_n = rstn; enable = en; div_load = ld; div_value = val;
    pll_locked = pll; lock_lost_clear = clr;
    if (!rstn) modelReset();
    else       modelStep(en, ld, val, pll, clr);
    expQ.push_back(modelOutputs());
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        for (int c = 0; c < NUM_CH; c++)
          checkOutput($sformatf("debug_clk_out[%0d]", c), int'(debug_clk_out[c]), int'(e.dbg[c]));
        checkOutput("heartbeat_led", int'(heartbeat_led), int'(e.led));
        checkOutput("lock_lost",     int'(lock_lost),     int'(e.lost));
        checkOutput("loss_count",    int'(loss_count),    e.loss);
        checkOutput("locked_sync",   int'(locked_sync),   int'(e.sync));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [NUM_CH*CNT_W-1:0] packDiv(int d0, int d1);
    logic [NUM_CH*CNT_W-1:0] v;
    v = '0;
    v[0 +: CNT_W]     = CNT_W'(d0);
    v[CNT_W +: CNT_W] = CNT_W'(d1);
    return v;
  endfunction

  initial begin
    logic [NUM_CH*CNT_W-1:0] zeroV;
    bit pll;
    zeroV = '0;
    reset_n = 1'b0; enable = 1'b0; div_load = 1'b0; div_value = '0;
    pll_locked = 1'b0; lock_lost_clear = 1'b0;
    modelReset();

    $display("[TB] reset and default divide-by-1 operation");
    repeat (3) applyStimulus(0, 1, 0, zeroV, 1, 0);
    repeat (12) applyStimulus(1, 1, 0, zeroV, 1, 0);

    $display("[TB] running load: ch0=3, ch1=0");
    applyStimulus(1, 1, 1, packDiv(3, 0), 1, 0);
    repeat (20) applyStimulus(1, 1, 0, zeroV, 1, 0);

    $display("[TB] freeze with enable=0 mid-period at div=4");
    applyStimulus(1, 1, 1, packDiv(4, 4), 1, 0);
    repeat (13) applyStimulus(1, 1, 0, zeroV, 1, 0);
    repeat (10) applyStimulus(1, 0, 0, zeroV, 1, 0);
    repeat (15) applyStimulus(1, 1, 0, zeroV, 1, 0);

    $display("[TB] lock loss sequence");
    repeat (20) applyStimulus(1, 1, 0, zeroV, 1, 0);
    repeat (5)  applyStimulus(1, 1, 0, zeroV, 0, 0);
    repeat (10) applyStimulus(1, 1, 0, zeroV, 1, 0);
    repeat (10) applyStimulus(1, 1, 0, zeroV, 0, 0);
    repeat (10) applyStimulus(1, 1, 0, zeroV, 1, 0);

    $display("[TB] clear colliding with loss, counter saturation");
    for (int k = 0; k < 5; k++) begin
      repeat (4) applyStimulus(1, 1, 0, zeroV, 1, fallPending());
      repeat (4) applyStimulus(1, 1, 0, zeroV, 0, fallPending());
    end
    applyStimulus(1, 1, 0, zeroV, 0, 1);
    repeat (4) applyStimulus(1, 1, 0, zeroV, 1, 0);

    $display("[TB] reset mid-period with pending shadow");
    applyStimulus(1, 1, 1, packDiv(5, 5), 1, 0);
    repeat (12) applyStimulus(1, 1, 0, zeroV, 1, 0);
    applyStimulus(1, 1, 1, packDiv(7, 7), 1, 0);
    repeat (2) applyStimulus(1, 1, 0, zeroV, 1, 0);
    repeat (2) applyStimulus(0, 1, 0, zeroV, 1, 0);
    repeat (12) applyStimulus(1, 1, 0, zeroV, 1, 0);

    $display("[TB] random phase");
    pll = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      bit en, ld, clr, rstn;
      logic [NUM_CH*CNT_W-1:0] v;
      en   = ($urandom_range(0, 9) != 0);
      ld   = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 14) == 0);
      rstn = ($urandom_range(0, 399) != 0);
      v    = packDiv($urandom_range(0, 6), $urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) pll = !pll;
      applyStimulus(rstn, en, ld, v, pll, clr);
    end

    @(posedge clk);
    #2;
    checkOutput("queue_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
